univ_shift_reg: RTL

Parametrised successor to the single-bit D flip-flop with set/reset. It provides a WIDTH-bit register bank with:
- asynchronous active-low reset;
- synchronous clear and set;
- clock enable;
- four operating modes: hold, shift right, shift left, parallel load.

A shift counter flags each completed WIDTH-bit serial word. It sits between serial links and parallel datapaths as the team's general-purpose SIPO/PISO/storage register.

---
 rtl/usr_pkg.sv | 11 +
 rtl/usr_word_counter.sv | 39 +++
 rtl/univ_shift_reg.sv | 70 +++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
package usr_pkg;

   typedef enum logic [1:0] {
      USR_HOLD = 2'b00,
      USR_SHR  = 2'b01,
      USR_SHL  = 2'b10,
      USR_LOAD = 2'b11
   } usr_mode_e;

endpackage : usr_pkg

// File: rtl/usr_word_counter.sv
// Mod-WIDTH shift counter with a registered one-cycle wrap pulse.
// clr wins over inc; with neither asserted the count holds and the pulse drops.
module usr_word_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // Count completed shifts; wrap at WIDTH-1 so non-power-of-two widths close words correctly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else if (inc) begin
         if (cnt == LAST) begin
            cnt  <= '0;
            wrap <= 1'b1;
         end else begin
            cnt  <= cnt + ONE;
            wrap <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule : usr_word_counter

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shift right, shift left, parallel load,
// with synchronous clear/set and a word-completion counter for SIPO/PISO use.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             set,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             word_done
);

   usr_mode_e mode_e;
   logic      do_shift;
   logic      cnt_clr;

   assign mode_e = usr_mode_e'(mode);

   // A shift only counts when it actually executes, i.e. not overridden by clr/set.
   assign do_shift = !clr && !set && en && ((mode_e == USR_SHR) || (mode_e == USR_SHL));
   // A load starts a fresh word, as do clear and set.
   assign cnt_clr  = clr || set || (en && (mode_e == USR_LOAD));

   // Register datapath: clr > set > enabled mode operation > hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= RESET_VAL;
      end else if (clr) begin
         q <= '0;
      end else if (set) begin
         q <= '1;
      end else if (en) begin
         case (mode_e)
            USR_SHR:  q <= {sin_r, q[WIDTH-1:1]};
            USR_SHL:  q <= {q[WIDTH-2:0], sin_l};
            USR_LOAD: q <= d;
            default:  q <= q;
         endcase
      end
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

   usr_word_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_word_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .inc     (do_shift),
      .cnt     (shift_cnt),
      .wrap    (word_done)
   );

endmodule : univ_shift_reg
